// File: rtl/qmem_arbiter.sv
// qmem_arbiter: round-robin arbiter sharing one qmem slave port among MN masters.
// The grant is registered and held from request until ack/err (or abort).
// Read data is broadcast; ack/err are routed only to the granted master.
// Optional feature: define QMEM_ARB_TIMEOUT_EN to add a TOW-bit transfer timeout.
module qmem_arbiter #(
  parameter int unsigned QAW = 32,
  parameter int unsigned QDW = 32,
  parameter int unsigned QSW = QDW / 8,
  parameter int unsigned MN  = 2,
  parameter int unsigned TOW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MN-1:0]     qm_cs_i,
  input  logic [MN-1:0]     qm_we_i,
  input  logic [MN*QAW-1:0] qm_adr_i,
  input  logic [MN*QSW-1:0] qm_sel_i,
  input  logic [MN*QDW-1:0] qm_dat_w_i,
  output logic [QDW-1:0]    qm_dat_r_o,
  output logic [MN-1:0]     qm_ack_o,
  output logic [MN-1:0]     qm_err_o,
  output logic              qs_cs_o,
  output logic              qs_we_o,
  output logic [QAW-1:0]    qs_adr_o,
  output logic [QSW-1:0]    qs_sel_o,
  output logic [QDW-1:0]    qs_dat_w_o,
  input  logic [QDW-1:0]    qs_dat_r_i,
  input  logic              qs_ack_i,
  input  logic              qs_err_i,
  output logic [MN-1:0]     gnt_o
);

  localparam int unsigned IW = (MN > 1) ? $clog2(MN) : 1;

  typedef enum logic {ARB, XFER} state_t;

  state_t          state_q, state_d;
  logic [MN-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;

  logic            xfer;
  logic            cs_g;
  logic [IW-1:0]   gidx;
  logic            to_fire;
  logic            done;
  logic [MN-1:0]   req;
  logic [IW-1:0]   base;
  logic [IW-1:0]   win;
  logic            win_vld;

  assign xfer       = (state_q == XFER);
  assign cs_g       = |(qm_cs_i & gnt_q);
  assign qm_dat_r_o = qs_dat_r_i;
  assign gnt_o      = gnt_q;

  // Index of the granted master (0 when idle)
  always_comb begin
    gidx = '0;
    for (int i = 0; i < MN; i++) begin
      if (gnt_q[i]) gidx = IW'(i);
    end
  end

  // Route the granted master's request fields to the slave port
  always_comb begin
    qs_we_o    = 1'b0;
    qs_adr_o   = '0;
    qs_sel_o   = '0;
    qs_dat_w_o = '0;
    for (int i = 0; i < MN; i++) begin
      if (gnt_q[i]) begin
        qs_we_o    = qm_we_i[i];
        qs_adr_o   = qm_adr_i[QAW*i +: QAW];
        qs_sel_o   = qm_sel_i[QSW*i +: QSW];
        qs_dat_w_o = qm_dat_w_i[QDW*i +: QDW];
      end
    end
  end

  assign qs_cs_o  = xfer & cs_g & ~to_fire;
  assign done     = (qs_cs_o & (qs_ack_i | qs_err_i)) | to_fire;
  assign qm_ack_o = gnt_q & {MN{qs_ack_i & ~to_fire}};
  assign qm_err_o = gnt_q & {MN{qs_err_i | to_fire}};

  // During a transfer the current owner is masked so others get the next turn
  assign req  = xfer ? (qm_cs_i & ~gnt_q) : qm_cs_i;
  assign base = xfer ? gidx : last_q;

  // Round-robin winner: first requester after base, wrapping modulo MN
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= MN; k++) begin
      idx = 32'(base) + k;
      if (idx >= MN) idx = idx - MN;
      if (!win_vld && req[IW'(idx)]) begin
        win     = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic: grant, hand over back-to-back, release, or abort
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB: begin
        if (win_vld) begin
          gnt_d   = MN'(1) << win;
          state_d = XFER;
        end
      end
      XFER: begin
        if (done) begin
          last_d = gidx;
          if (win_vld) begin
            gnt_d = MN'(1) << win;
          end else begin
            gnt_d   = '0;
            state_d = ARB;
          end
        end else if (!cs_g) begin
          gnt_d   = '0;
          state_d = ARB;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB;
      end
    endcase
  end

  // State, grant and priority registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB;
      gnt_q   <= '0;
      last_q  <= IW'(MN - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef QMEM_ARB_TIMEOUT_EN
  logic [TOW-1:0] to_q, to_d;
  logic           grant;

  assign grant   = win_vld & (~xfer | done);
  assign to_fire = xfer & cs_g & (&to_q);

  // Timeout counter: cleared on every grant, counts waiting slave cycles
  always_comb begin
    to_d = to_q;
    if (grant) begin
      to_d = '0;
    end else if (qs_cs_o && !done) begin
      to_d = to_q + TOW'(1);
    end
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  // No counter: a transfer waits for the slave indefinitely (TOW is >= 1, so this is 0)
  assign to_fire = (TOW == 0);
`endif

endmodule

// File: tb/tb_qmem_arbiter.sv
// Self-checking bench for qmem_arbiter (MN=2): directed vectors, a per-cycle
// behavioural model of the arbitration rules, and literal expectations.
module tb_qmem_arbiter;

  localparam int unsigned QAW = 32;
  localparam int unsigned QDW = 32;
  localparam int unsigned QSW = 4;
  localparam int unsigned MN  = 2;
  localparam int unsigned TOW = 4;

  logic              clk;
  logic              rst;
  logic [MN-1:0]     qm_cs;
  logic [MN-1:0]     qm_we;
  logic [MN*QAW-1:0] qm_adr;
  logic [MN*QSW-1:0] qm_sel;
  logic [MN*QDW-1:0] qm_dat_w;
  logic [QDW-1:0]    qm_dat_r;
  logic [MN-1:0]     qm_ack;
  logic [MN-1:0]     qm_err;
  logic              qs_cs;
  logic              qs_we;
  logic [QAW-1:0]    qs_adr;
  logic [QSW-1:0]    qs_sel;
  logic [QDW-1:0]    qs_dat_w;
  logic [QDW-1:0]    qs_dat_r;
  logic              qs_ack;
  logic              qs_err;
  logic [MN-1:0]     gnt;

  qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .TOW(TOW)) dut (
    .clk(clk), .rst(rst),
    .qm_cs_i(qm_cs), .qm_we_i(qm_we), .qm_adr_i(qm_adr), .qm_sel_i(qm_sel),
    .qm_dat_w_i(qm_dat_w), .qm_dat_r_o(qm_dat_r), .qm_ack_o(qm_ack), .qm_err_o(qm_err),
    .qs_cs_o(qs_cs), .qs_we_o(qs_we), .qs_adr_o(qs_adr), .qs_sel_o(qs_sel),
    .qs_dat_w_o(qs_dat_w), .qs_dat_r_i(qs_dat_r), .qs_ack_i(qs_ack), .qs_err_i(qs_err),
    .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: owner (-1 = nobody), last completed master, timeout count
  int m_owner, m_last, m_cnt;
  int n_owner, n_last, n_cnt;
  bit model_ok = 1'b0;

  function automatic int pick(input logic [MN-1:0] r, input int from);
    for (int k = 1; k <= int'(MN); k++) begin
      int j;
      j = (from + k) % int'(MN);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Compare DUT against the model each cycle and compute the model's next step
  always @(negedge clk) begin
    bit fire, ecs, done;
    logic [MN-1:0] egnt, eack, eerr, others;
    fire = 1'b0;
`ifdef QMEM_ARB_TIMEOUT_EN
    fire = (m_owner >= 0) && qm_cs[m_owner] && (m_cnt == (1 << TOW) - 1);
`endif
    ecs  = (m_owner >= 0) && qm_cs[m_owner] && !fire;
    egnt = '0;
    eack = '0;
    eerr = '0;
    if (m_owner >= 0) begin
      egnt[m_owner] = 1'b1;
      eack[m_owner] = qs_ack && !fire;
      eerr[m_owner] = qs_err || fire;
    end
    if (model_ok) begin
      chk("m_gnt", gnt, egnt);
      chk("m_qs_cs", qs_cs, ecs);
      chk("m_qm_ack", qm_ack, eack);
      chk("m_qm_err", qm_err, eerr);
      chk("m_dat_r", qm_dat_r, qs_dat_r);
      if (ecs) begin
        chk("m_qs_we", qs_we, qm_we[m_owner]);
        chk("m_qs_adr", qs_adr, qm_adr[m_owner*QAW +: QAW]);
        chk("m_qs_sel", qs_sel, qm_sel[m_owner*QSW +: QSW]);
        chk("m_qs_dat_w", qs_dat_w, qm_dat_w[m_owner*QDW +: QDW]);
      end
    end
    n_owner = m_owner;
    n_last  = m_last;
    n_cnt   = m_cnt;
    done    = (ecs && (qs_ack || qs_err)) || fire;
    if (m_owner < 0) begin
      if (qm_cs != '0) begin
        n_owner = pick(qm_cs, m_last);
        n_cnt   = 0;
      end
    end else if (done) begin
      n_last  = m_owner;
      others  = qm_cs;
      others[m_owner] = 1'b0;
      n_owner = pick(others, m_owner);
      n_cnt   = 0;
    end else if (!qm_cs[m_owner]) begin
      n_owner = -1;
    end else begin
      n_cnt = m_cnt + 1;
    end
  end

  // Advance the model on the clock edge
  always @(posedge clk) begin
    if (!rst) begin
      m_owner  = -1;
      m_last   = int'(MN) - 1;
      m_cnt    = 0;
      model_ok = 1'b1;
    end else begin
      m_owner = n_owner;
      m_last  = n_last;
      m_cnt   = n_cnt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input bit cs, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    qm_cs[i] = cs;
    qm_we[i] = we;
    qm_adr[i*QAW +: QAW]   = adr;
    qm_sel[i*QSW +: QSW]   = sel;
    qm_dat_w[i*QDW +: QDW] = dat;
  endtask

  logic [MN-1:0] rr_exp [4];
  int cs_cycles;

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0; qm_cs = '0; qm_we = '0; qm_adr = '0; qm_sel = '0; qm_dat_w = '0;
    qs_dat_r = '0; qs_ack = 1'b0; qs_err = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1 chk("reset_gnt", gnt, 2'b00);
    chk("reset_qs_cs", qs_cs, 1'b0);

    // Idle
    repeat (10) cyc();
    #1 chk("idle_qs_cs", qs_cs, 1'b0);
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_ack", qm_ack, 2'b00);

    // Single read by master 1, ack on 3rd cs cycle
    cyc();
    set_m(1, 1'b1, 1'b0, 32'h100, 4'hf, 32'h0);
    #1 chk("rd_lat_cs0", qs_cs, 1'b0);
    cyc();
    #1 chk("rd_qs_cs", qs_cs, 1'b1);
    chk("rd_gnt", gnt, 2'b10);
    chk("rd_adr", qs_adr, 32'h100);
    cyc();
    cyc();
    qs_ack = 1'b1;
    #1 chk("rd_ack", qm_ack, 2'b10);
    cyc();
    qs_ack = 1'b0; qm_cs[1] = 1'b0; qs_dat_r = 32'hCAFEF00D;
    #1 chk("rd_data", qm_dat_r, 32'hCAFEF00D);
    chk("rd_release", gnt, 2'b00);
    cyc();
    qs_dat_r = '0;

    // Contention: both request, slave acks every cycle
    cyc();
    set_m(0, 1'b1, 1'b0, 32'h10, 4'h1, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h20, 4'h2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      qs_ack = 1'b1;
      #1 chk($sformatf("rr_gnt%0d", i), gnt, rr_exp[i]);
      chk($sformatf("rr_ack%0d", i), qm_ack, rr_exp[i]);
    end
    cyc();
    qm_cs = '0; qs_ack = 1'b0;
    cyc();

    // Error routing on master 0 write, master 1 waiting
    cyc();
    set_m(0, 1'b1, 1'b1, 32'h200, 4'h3, 32'h12345678);
    set_m(1, 1'b1, 1'b0, 32'h300, 4'hc, 32'h0);
    cyc();
    qs_err = 1'b1;
    #1 chk("err_gnt", gnt, 2'b01);
    chk("err_route", qm_err, 2'b01);
    chk("err_no_ack", qm_ack, 2'b00);
    chk("err_wdata", qs_dat_w, 32'h12345678);
    cyc();
    qs_err = 1'b0; qm_cs[0] = 1'b0; qs_ack = 1'b1;
    #1 chk("err_next_gnt", gnt, 2'b10);
    chk("err_next_ack", qm_ack, 2'b10);
    cyc();
    qm_cs = '0; qs_ack = 1'b0;
    cyc();

    // Abort by master 0; last stays at master 1
    qm_cs[0] = 1'b1;
    cyc();
    #1 chk("abort_gnt0", gnt, 2'b01);
    cyc();
    qm_cs[0] = 1'b0;
    #1 chk("abort_cs", qs_cs, 1'b0);
    cyc();
    #1 chk("abort_idle", gnt, 2'b00);
    qm_cs = 2'b11;
    cyc();
    qs_ack = 1'b1;
    #1 chk("abort_last_kept", gnt, 2'b01);
    cyc();
    qm_cs[0] = 1'b0;
    #1 chk("abort_b2b", gnt, 2'b10);
    cyc();
    qm_cs = '0; qs_ack = 1'b0;
    cyc();

    // Reset in the middle of a transfer
    qm_cs[1] = 1'b1;
    cyc();
    #1 chk("rstmid_gnt", gnt, 2'b10);
    rst = 1'b0;
    cyc();
    rst = 1'b1; qm_cs = 2'b11;
    #1 chk("rstmid_drop", qs_cs, 1'b0);
    chk("rstmid_gnt0", gnt, 2'b00);
    chk("rstmid_noack", qm_ack, 2'b00);
    cyc();
    #1 chk("rst_prio", gnt, 2'b01);
    qm_cs = '0;
    cyc();
    cyc();

`ifdef QMEM_ARB_TIMEOUT_EN
    // Timeout: slave never answers
    qm_cs[0] = 1'b1;
    cyc();
    cs_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (qm_err != '0) break;
      if (qs_cs) cs_cycles++;
      cyc();
    end
    chk("to_cycles", cs_cycles, 15);
    chk("to_err", qm_err, 2'b01);
    chk("to_cs_forced", qs_cs, 1'b0);
    cyc();
    qm_cs = '0;
    #1 chk("to_release", gnt, 2'b00);
    cyc();
`else
    cs_cycles = 0;
`endif

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
